// File: rtl/bip_cpu.sv
// BIP accumulator CPU: multi-cycle fetch/decode/execute/write-back core driving
// synchronous program and data memories, with halt flag and saturating cycle counter.
module bip_cpu #(
   parameter int NB_DATA          = 16,
   parameter int NB_OPCODE        = 5,
   parameter int NB_OPERAND       = 11,
   parameter int LOG2_N_DATA_ADDR = 10,
   parameter int NB_COUNT         = 32
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_enable,
   input  logic [NB_DATA-1:0]          i_instr,
   input  logic [NB_DATA-1:0]          i_data_rd,
   output logic [NB_OPERAND-1:0]       o_pc_addr,
   output logic                        o_instr_rd,
   output logic [LOG2_N_DATA_ADDR-1:0] o_data_addr,
   output logic [NB_DATA-1:0]          o_data_wr,
   output logic                        o_wr,
   output logic                        o_rd,
   output logic [NB_DATA-1:0]          o_acc,
   output logic                        o_halt,
   output logic [NB_COUNT-1:0]         o_clk_count
);

   localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
   localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
   localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
   localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
   localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
   localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
   localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
   localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [NB_OPERAND-1:0]   r_pc;
   logic [NB_OPERAND-1:0]   w_pc_next;
   logic [NB_DATA-1:0]      r_ir;
   logic [NB_DATA-1:0]      w_ir_next;
   logic [NB_DATA-1:0]      r_acc;
   logic [NB_DATA-1:0]      w_acc_next;
   logic [NB_COUNT-1:0]     r_count;
   logic                    w_rd;
   logic                    w_wr;
   logic                    w_instr_rd;
   logic                    w_run;
   logic [NB_OPCODE-1:0]    w_opcode;
   logic [NB_DATA-1:0]      w_imm_sext;
   logic [NB_OPERAND-1:0]   w_pc_inc;

   assign w_opcode   = r_ir[NB_DATA-1 -: NB_OPCODE];
   assign w_imm_sext = {{(NB_DATA-NB_OPERAND){r_ir[NB_OPERAND-1]}}, r_ir[NB_OPERAND-1:0]};
   assign w_pc_inc   = r_pc + NB_OPERAND'(1);
   // Memory enables are suppressed while stalled or in reset so nothing is issued then.
   assign w_run      = i_enable & ~i_reset;

   // Next-state, datapath updates and raw memory enables.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_ir_next    = r_ir;
      w_acc_next   = r_acc;
      w_rd         = 1'b0;
      w_wr         = 1'b0;
      w_instr_rd   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_instr_rd   = 1'b1;
            w_state_next = S_DECODE;
         end
         S_DECODE: begin
            w_ir_next    = i_instr;
            w_state_next = S_EXEC;
         end
         S_EXEC: begin
            w_pc_next    = w_pc_inc;
            w_state_next = S_FETCH;
            case (w_opcode)
               OP_HLT: begin
                  w_pc_next    = r_pc;
                  w_state_next = S_HALT;
               end
               OP_STO:  w_wr = 1'b1;
               OP_LD, OP_ADD, OP_SUB: begin
                  w_rd         = 1'b1;
                  w_pc_next    = r_pc;
                  w_state_next = S_WB;
               end
               OP_LDI:  w_acc_next = w_imm_sext;
               OP_ADDI: w_acc_next = r_acc + w_imm_sext;
               OP_SUBI: w_acc_next = r_acc - w_imm_sext;
               default: w_acc_next = r_acc;
            endcase
         end
         S_WB: begin
            w_pc_next    = w_pc_inc;
            w_state_next = S_FETCH;
            case (w_opcode)
               OP_LD:   w_acc_next = i_data_rd;
               OP_ADD:  w_acc_next = r_acc + i_data_rd;
               OP_SUB:  w_acc_next = r_acc - i_data_rd;
               default: w_acc_next = r_acc;
            endcase
         end
         S_HALT:  w_state_next = S_HALT;
         default: w_state_next = S_FETCH;
      endcase
   end

   // Architectural state and cycle counter; i_enable low freezes everything.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
         r_acc   <= '0;
         r_count <= '0;
      end else if (i_enable) begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_ir    <= w_ir_next;
         r_acc   <= w_acc_next;
         if ((r_state != S_HALT) && (r_count != {NB_COUNT{1'b1}}))
            r_count <= r_count + NB_COUNT'(1);
      end
   end

   assign o_pc_addr   = r_pc;
   assign o_instr_rd  = w_instr_rd & w_run;
   assign o_rd        = w_rd & w_run;
   assign o_wr        = w_wr & w_run;
   assign o_data_addr = r_ir[LOG2_N_DATA_ADDR-1:0];
   assign o_data_wr   = r_acc;
   assign o_acc       = r_acc;
   assign o_halt      = (r_state == S_HALT) & ~i_reset;
   assign o_clk_count = r_count;

endmodule

// File: tb/tb_bip_cpu.sv
// Bench for bip_cpu: synchronous memory models, ISA-level reference interpreter,
// directed scenarios and randomized programs with random stalls.
module tb_bip_cpu;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_enable = 1'b0;
   logic [15:0] i_instr;
   logic [15:0] i_data_rd;
   logic [10:0] o_pc_addr;
   logic        o_instr_rd;
   logic [9:0]  o_data_addr;
   logic [15:0] o_data_wr;
   logic        o_wr;
   logic        o_rd;
   logic [15:0] o_acc;
   logic        o_halt;
   logic [31:0] o_clk_count;

   logic [15:0] prog [0:2047];
   logic [15:0] dmem [0:1023];
   logic [15:0] mref [0:1023];
   logic [15:0] instr_q = 16'h0000;
   logic [15:0] data_q  = 16'h0000;
   int          n_checks = 0;
   int          n_fail   = 0;

   bip_cpu dut (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_enable   (i_enable),
      .i_instr    (i_instr),
      .i_data_rd  (i_data_rd),
      .o_pc_addr  (o_pc_addr),
      .o_instr_rd (o_instr_rd),
      .o_data_addr(o_data_addr),
      .o_data_wr  (o_data_wr),
      .o_wr       (o_wr),
      .o_rd       (o_rd),
      .o_acc      (o_acc),
      .o_halt     (o_halt),
      .o_clk_count(o_clk_count)
   );

   always #5 i_clock = ~i_clock;

   // Synchronous memories hold their read data while their enable is low.
   always @(posedge i_clock) begin
      if (o_instr_rd) instr_q <= prog[o_pc_addr];
      if (o_rd)       data_q  <= dmem[o_data_addr];
      if (o_wr)       dmem[o_data_addr] <= o_data_wr;
   end
   assign i_instr   = instr_q;
   assign i_data_rd = data_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Bus rules: one enable at a time, nothing issued while stalled.
   always @(negedge i_clock) begin
      #1;
      if (!i_reset) begin
         check("enable_excl", 32'(int'(o_rd) + int'(o_wr) + int'(o_instr_rd) <= 1), 32'd1);
         if (!i_enable) check("stall_enables", {29'd0, o_rd, o_wr, o_instr_rd}, 32'd0);
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
      for (int i = 0; i < 1024; i++) begin
         dmem[i] = 16'h0000;
         mref[i] = 16'h0000;
      end
   endtask

   task automatic do_reset(input bit chk);
      @(negedge i_clock);
      i_reset  = 1'b1;
      i_enable = 1'b1;
      #1;
      if (chk) check("rst_enables", {29'd0, o_rd, o_wr, o_instr_rd}, 32'd0);
      @(negedge i_clock);
      if (chk) begin
         check("rst_acc", {16'd0, o_acc}, 32'd0);
         check("rst_pc", {21'd0, o_pc_addr}, 32'd0);
         check("rst_count", o_clk_count, 32'd0);
         check("rst_halt", {31'd0, o_halt}, 32'd0);
      end
      i_reset = 1'b0;
   endtask

   // mode 0: always enabled, 1: random stalls, 2: one active cycle then five stalled.
   task automatic run_to_halt(input int budget, input int mode);
      int n  = 0;
      int ph = 0;
      while (!o_halt && n < budget) begin
         @(negedge i_clock);
         case (mode)
            1: i_enable = ($urandom_range(0, 3) != 0);
            2: begin
               i_enable = (ph == 0);
               ph = (ph + 1) % 6;
            end
            default: i_enable = 1'b1;
         endcase
         n++;
      end
      i_enable = 1'b1;
      check("halt_reached", {31'd0, o_halt}, 32'd1);
   endtask

   // ISA-level interpreter over prog/mref: returns final ACC, PC and cycles spent.
   task automatic ref_run(output logic [15:0] acc, output logic [10:0] pc, output int cycles);
      logic [15:0] ins;
      logic [15:0] imm;
      int          a;
      acc = 16'd0;
      pc = 11'd0;
      cycles = 0;
      for (int step = 0; step < 5000; step++) begin
         ins = prog[pc];
         imm = 16'($signed(ins[10:0]));
         a = int'(ins[9:0]);
         cycles += 3;
         if (ins[15:11] == 5'd0) break;
         case (ins[15:11])
            5'd1: mref[a] = acc;
            5'd2: begin acc = mref[a]; cycles += 1; end
            5'd3: acc = imm;
            5'd4: begin acc = acc + mref[a]; cycles += 1; end
            5'd5: acc = acc + imm;
            5'd6: begin acc = acc - mref[a]; cycles += 1; end
            5'd7: acc = acc - imm;
            default: ;
         endcase
         pc = pc + 11'd1;
      end
   endtask

   logic [15:0] e_acc;
   logic [10:0] e_pc;
   int          e_cyc;
   int          n_wait;
   logic [4:0]  op;
   logic [10:0] opnd;

   initial begin
      // Basic program with negative immediate, store and load back.
      clear_mem();
      prog[0] = 16'h1805; prog[1] = 16'h2FFD; prog[2] = 16'h0807;
      prog[3] = 16'h1007; prog[4] = 16'h0000;
      do_reset(1'b1);
      run_to_halt(200, 0);
      check("t1_mem7", {16'd0, dmem[7]}, 32'd2);
      check("t1_acc", {16'd0, o_acc}, 32'd2);
      check("t1_count", o_clk_count, 32'd16);
      check("t1_pc", {21'd0, o_pc_addr}, 32'd4);
      repeat (3) @(negedge i_clock);
      check("t1_count_hold", o_clk_count, 32'd16);
      check("t1_halt_hold", {31'd0, o_halt}, 32'd1);

      // Wraparound through 0x8000 and back.
      clear_mem();
      dmem[3] = 16'h7FFF;
      prog[0] = 16'h1801; prog[1] = 16'h2003; prog[2] = 16'h3003; prog[3] = 16'h0000;
      do_reset(1'b0);
      repeat (7) @(negedge i_clock);
      check("t2_acc_after_add", {16'd0, o_acc}, 32'h8000);
      run_to_halt(200, 0);
      check("t2_acc_final", {16'd0, o_acc}, 32'h0001);
      check("t2_count", o_clk_count, 32'd14);

      // ADD with every state stalled for five cycles.
      clear_mem();
      dmem[3] = 16'd20;
      prog[0] = 16'h180A; prog[1] = 16'h2003; prog[2] = 16'h0000;
      do_reset(1'b0);
      run_to_halt(400, 2);
      check("t3_acc", {16'd0, o_acc}, 32'd30);
      check("t3_count", o_clk_count, 32'd10);

      // Reset during write-back of LD.
      clear_mem();
      dmem[7] = 16'h1234;
      prog[0] = 16'h1805; prog[1] = 16'h1007; prog[2] = 16'h0000;
      do_reset(1'b0);
      n_wait = 0;
      while (!o_rd && n_wait < 50) begin @(negedge i_clock); n_wait++; end
      check("t4_saw_rd", {31'd0, o_rd}, 32'd1);
      @(negedge i_clock);
      i_reset = 1'b1;
      #1;
      check("t4_rd_in_reset", {30'd0, o_rd, o_wr}, 32'd0);
      @(negedge i_clock);
      check("t4_acc", {16'd0, o_acc}, 32'd0);
      check("t4_pc", {21'd0, o_pc_addr}, 32'd0);
      i_reset = 1'b0;
      #1;
      check("t4_refetch", {20'd0, o_instr_rd, o_pc_addr}, {20'd0, 1'b1, 11'd0});
      run_to_halt(200, 0);
      check("t4_acc_final", {16'd0, o_acc}, 32'h1234);

      // Reset during EXEC of STO must not write.
      clear_mem();
      dmem[9] = 16'hAAAA;
      prog[0] = 16'h1855; prog[1] = 16'h0809; prog[2] = 16'h0000;
      do_reset(1'b0);
      n_wait = 0;
      while (!o_wr && n_wait < 50) begin @(negedge i_clock); n_wait++; end
      check("t4b_saw_wr", {31'd0, o_wr}, 32'd1);
      i_reset = 1'b1;
      #1;
      check("t4b_wr_in_reset", {31'd0, o_wr}, 32'd0);
      @(negedge i_clock);
      i_reset = 1'b0;
      check("t4b_mem_kept", {16'd0, dmem[9]}, 32'hAAAA);

      // Undefined opcode behaves as NOP.
      clear_mem();
      prog[0] = 16'hF800; prog[1] = 16'h1809; prog[2] = 16'h0000;
      do_reset(1'b0);
      run_to_halt(200, 0);
      check("t5_acc", {16'd0, o_acc}, 32'd9);
      check("t5_count", o_clk_count, 32'd9);

      // PC wrap 2047 -> 0; HLT placed at 0 once execution has moved past it.
      clear_mem();
      for (int i = 0; i < 2047; i++) prog[i] = 16'h4000;
      prog[2047] = 16'h1801;
      do_reset(1'b0);
      n_wait = 0;
      while (o_pc_addr != 11'd1 && n_wait < 50) begin @(negedge i_clock); n_wait++; end
      prog[0] = 16'h0000;
      run_to_halt(7000, 0);
      check("t6_acc", {16'd0, o_acc}, 32'd1);
      check("t6_pc", {21'd0, o_pc_addr}, 32'd0);
      check("t6_count", o_clk_count, 32'd6147);

      // Random straight-line programs with random stalls against the interpreter.
      for (int t = 0; t < 8; t++) begin
         clear_mem();
         for (int i = 0; i < 16; i++) begin
            dmem[i] = 16'($urandom);
            mref[i] = dmem[i];
         end
         for (int i = 0; i < 20; i++) begin
            op = 5'($urandom_range(1, 31));
            opnd = 11'($urandom);
            if (op == 5'd1 || op == 5'd2 || op == 5'd4 || op == 5'd6) opnd = opnd & 11'h40F;
            prog[i] = {op, opnd};
         end
         prog[20] = 16'h0000;
         ref_run(e_acc, e_pc, e_cyc);
         do_reset(1'b0);
         run_to_halt(1000, (t % 2 == 1) ? 1 : 0);
         check("rnd_acc", {16'd0, o_acc}, {16'd0, e_acc});
         check("rnd_pc", {21'd0, o_pc_addr}, {21'd0, e_pc});
         check("rnd_count", o_clk_count, 32'(e_cyc));
         for (int i = 0; i < 16; i++) check("rnd_mem", {16'd0, dmem[i]}, {16'd0, mref[i]});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bip_cpu.md
Name: bip_cpu

Overview:
Multi-cycle BIP accumulator CPU core that sits directly upstream of the BIP data memory and drives its address, write-data and read/write-enable ports. It fetches 16-bit instructions from a synchronous program memory, decodes the opcode and operand, and executes against a 16-bit accumulator. It halts on HLT and exports the accumulator, the halt flag and an executed-cycle counter for external reporting.

Parameters:
NB_DATA, 16, accumulator / data word / instruction width
NB_OPCODE, 5, opcode field width (instr[15:11])
NB_OPERAND, 11, operand field width (instr[10:0]); also PC width
LOG2_N_DATA_ADDR, 10, data memory address width (operand[9:0])
NB_COUNT, 32, cycle counter width

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  run enable; low freezes all state
i_instr  in  16  program memory read data, valid the cycle after o_instr_rd
i_data_rd  in  16  data memory o_data, valid the cycle after o_rd
o_pc_addr  out  11  program memory address (= PC register)
o_instr_rd  out  1  program memory read enable
o_data_addr  out  10  data memory address (= IR[9:0])
o_data_wr  out  16  data memory write data (= ACC)
o_wr  out  1  data memory write enable
o_rd  out  1  data memory read enable
o_acc  out  16  accumulator
o_halt  out  1  high in S_HALT
o_clk_count  out  32  executed-cycle counter

Behaviour:
- Reset (sync, priority over everything): PC=0, IR=0, ACC=0, count=0, state=S_FETCH; o_instr_rd=0 during the reset cycle, o_rd=o_wr=0, o_halt=0.
- States: S_FETCH -> S_DECODE -> S_EXEC -> (S_WB | S_FETCH | S_HALT).
- S_FETCH: o_instr_rd=1, o_pc_addr=PC; next S_DECODE.
- S_DECODE: IR<=i_instr; next S_EXEC.
- S_EXEC, by IR[15:11]:
  00000 HLT: next S_HALT; PC unchanged.
  00001 STO: o_wr=1, o_data_addr=IR[9:0], o_data_wr=ACC; PC++; next S_FETCH.
  00010 LD, 00100 ADD, 00110 SUB: o_rd=1, o_data_addr=IR[9:0]; next S_WB.
  00011 LDI: ACC<=sext(IR[10:0]); PC++; next S_FETCH.
  00101 ADDI / 00111 SUBI: ACC<=ACC +/- sext(IR[10:0]); PC++; next S_FETCH.
  Any other opcode: NOP; PC++; next S_FETCH.
- S_WB: LD: ACC<=i_data_rd; ADD: ACC+i_data_rd; SUB: ACC-i_data_rd; PC++; next S_FETCH.
- o_rd, o_wr and o_instr_rd are combinational from state/IR and never asserted together. o_rd/o_wr are 0 outside S_EXEC.
- Cycles per instruction: LDI/ADDI/SUBI/STO/NOP/HLT = 3, LD/ADD/SUB = 4.
- Arithmetic: two's complement modulo 2^16, no flags. Immediate is sign-extended from bit 10 (0x7FF -> 0xFFFF).
- PC is 11-bit and wraps 2047 -> 0.
- S_HALT: terminal state until reset. o_halt=1, all memory enables 0, ACC and PC held.
- i_enable=0: state, PC, IR, ACC and count hold; o_instr_rd, o_rd and o_wr are forced 0. Program and data memories hold their read data while their enables are low, so the operation resumes correctly when i_enable returns high.
- o_clk_count increments once per cycle with i_enable=1 and state != S_HALT. It saturates at all-ones.
- Reset mid-instruction (any state, including S_WB): the pending operation is abandoned and no write is issued in the reset cycle.

Test Plan:
- Program LDI 5; ADDI 0x7FD(-3); STO 7; LD 7; HLT -> mem[7]=2, o_acc=2, o_halt=1, o_clk_count=16, o_pc_addr=4.
- mem[3]=0x7FFF; LDI 1; ADD 3; SUB 3; HLT -> o_acc passes 0x8000 after ADD and returns to 0x0001 after SUB (wrap, no flags).
- Toggle i_enable low for 5 cycles at each state during an ADD -> same final ACC, o_clk_count unchanged by the stalled cycles, no enable asserted while stalled.
- Assert i_reset in S_WB of a LD -> next cycle o_acc=0, PC=0, o_rd=0, refetch from address 0.
- Undefined opcode 0x1F in the first slot followed by LDI 9; HLT -> treated as NOP, o_acc=9, o_clk_count=9.
- Preload PC=2047 via 2047 NOPs, with LDI 1 at 2047 and HLT at 0 -> PC wraps to 0, halts with o_acc=1.
